alu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer that performs unsigned MUL / UDIV / UREM by iterating the shared integer ALU.

---
 rtl/alu_muldiv_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL / UDIV / UREM sequencer that borrows the shared integer ALU
// through a req/gnt port: shift-and-add multiply, restoring divide.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned F_SZ  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [F_SZ-1:0]  alu_f,
    input  logic [WIDTH-1:0] alu_y
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [F_SZ-1:0] F_ADD = F_SZ'(2);
    localparam logic [F_SZ-1:0] F_SUB = F_SZ'(6);
    localparam logic [F_SZ-1:0] F_SLT = F_SZ'(7);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CMP,
        S_DIV_SUB,
        S_FIN
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] p_q;
    logic             lt_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] p_cur;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    // Partial remainder shifted left by one with the next dividend bit; its lost
    // top bit (rem msb) means p already exceeds any WIDTH-bit divisor.
    assign p_cur     = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign rem_next  = lt_q ? p_q : alu_y;
    assign quo_next  = {quo[WIDTH-2:0], ~lt_q};
    assign last_step = (cnt == CNT_W'(1));

    always_comb begin
        alu_req = 1'b0;
        alu_opA = '0;
        alu_opB = '0;
        alu_f   = F_ADD;
        case (state)
            S_MUL: begin
                alu_req = 1'b1;
                alu_f   = F_ADD;
                alu_opA = acc;
                alu_opB = mp[0] ? mc : '0;
            end
            S_DIV_CMP: begin
                alu_req = 1'b1;
                alu_f   = F_SLT;
                alu_opA = p_cur;
                alu_opB = b_q;
            end
            S_DIV_SUB: begin
                if (!lt_q) begin
                    alu_req = 1'b1;
                    alu_f   = F_SUB;
                    alu_opA = p_q;
                    alu_opB = b_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            op_q        <= '0;
            b_q         <= '0;
            acc         <= '0;
            mc          <= '0;
            mp          <= '0;
            rem         <= '0;
            quo         <= '0;
            p_q         <= '0;
            lt_q        <= 1'b0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        b_q         <= b;
                        cnt         <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                        if (op == OP_MUL) begin
                            acc   <= '0;
                            mc    <= a;
                            mp    <= b;
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else if (op == OP_ILL) begin
                            result     <= '0;
                            illegal_op <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_FIN;
                        end else if (b == '0) begin
                            result      <= (op == OP_UDIV) ? '1 : a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_FIN;
                        end else begin
                            rem   <= '0;
                            quo   <= a;
                            busy  <= 1'b1;
                            state <= S_DIV_CMP;
                        end
                    end
                end

                S_MUL: begin
                    if (alu_gnt) begin
                        acc <= alu_y;
                        mc  <= mc << 1;
                        mp  <= mp >> 1;
                        cnt <= cnt - CNT_W'(1);
                        if (last_step) begin
                            result <= alu_y;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end

                S_DIV_CMP: begin
                    if (alu_gnt) begin
                        lt_q  <= alu_y[0] & ~rem[WIDTH-1];
                        p_q   <= p_cur;
                        state <= S_DIV_SUB;
                    end
                end

                S_DIV_SUB: begin
                    // The no-subtract case needs no ALU, so it retires without a grant.
                    if (lt_q || alu_gnt) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt - CNT_W'(1);
                        if (last_step) begin
                            result <= (op_q == OP_UDIV) ? quo_next : rem_next;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            state <= S_DIV_CMP;
                        end
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq: directed cases plus random ops
// compared against plain-arithmetic results, cycle-exact latency and grant stalls.
module tb_alu_muldiv_seq;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          div_by_zero;
    logic          illegal_op;
    logic          alu_req;
    logic          alu_gnt;
    logic [W-1:0]  alu_opA;
    logic [W-1:0]  alu_opB;
    logic [3:0]    alu_f;
    logic [W-1:0]  alu_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W), .F_SZ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_f      (alu_f),
        .alu_y      (alu_y)
    );

    // Shared integer ALU: ADD, SUB, unsigned set-less-than
    always_comb begin
        case (alu_f)
            4'b0010: alu_y = alu_opA + alu_opB;
            4'b0110: alu_y = alu_opA - alu_opB;
            4'b0111: alu_y = {{(W-1){1'b0}}, (alu_opA < alu_opB)};
            default: alu_y = '0;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic dz, output logic il,
                                      output int lat);
        dz = 1'b0;
        il = 1'b0;
        case (o)
            2'd0: begin r = x * y; lat = W + 1; end
            2'd1: if (y == 0) begin r = '1; dz = 1'b1; lat = 1; end
                  else begin r = x / y; lat = 2 * W + 1; end
            2'd2: if (y == 0) begin r = x; dz = 1'b1; lat = 1; end
                  else begin r = x % y; lat = 2 * W + 1; end
            default: begin r = '0; il = 1'b1; lat = 1; end
        endcase
    endfunction

    // Called with the DUT idle, just after a rising edge. gmode: 0 grant always,
    // 1 grant toggles 1/0, 2 random grant. Returns just after the cycle following done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int gmode, input bit inject, input string tag);
        logic [W-1:0] er;
        logic         edz;
        logic         eil;
        int           lat;
        int           stalls = 0;
        int           cyc = 1;
        int           req_cnt = 0;
        int           busy_err = 0;
        int           stab_err = 0;
        bit           prev_stall = 1'b0;
        bit           got = 1'b0;
        logic [W-1:0] sv_a;
        logic [W-1:0] sv_b;
        logic [3:0]   sv_f;

        ref_model(o, x, y, er, edz, eil, lat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        while (cyc <= 2000 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (prev_stall && (!alu_req || alu_opA !== sv_a || alu_opB !== sv_b || alu_f !== sv_f))
                    stab_err++;
                if (!busy) busy_err++;
                case (gmode)
                    0:       alu_gnt = 1'b1;
                    1:       alu_gnt = (cyc % 2 == 1);
                    default: alu_gnt = 1'($urandom_range(0, 1));
                endcase
                if (inject && cyc == 10) begin
                    start = 1'b1; op = ~o; a = 64'd1000; b = 64'd3;
                end else begin
                    start = 1'b0;
                end
                prev_stall = alu_req && !alu_gnt;
                if (prev_stall) begin
                    stalls++;
                    sv_a = alu_opA; sv_b = alu_opB; sv_f = alu_f;
                end
                if (alu_req) req_cnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, got ? W'(cyc) : '0, W'(lat + stalls));
        check({tag, ".result"}, result, er);
        check({tag, ".div_by_zero"}, W'(div_by_zero), W'(edz));
        check({tag, ".illegal_op"}, W'(illegal_op), W'(eil));
        check({tag, ".busy_at_done"}, W'(busy), '0);
        check({tag, ".busy_while_running"}, W'(busy_err), '0);
        if (o == 2'd0 && gmode == 0)
            check({tag, ".alu_req_cycles"}, W'(req_cnt), W'(W));
        if (stalls > 0)
            check({tag, ".stall_stable"}, W'(stab_err), '0);
        alu_gnt = 1'b1;
        @(posedge clk); #1;
        check({tag, ".done_one_cycle"}, W'(done), '0);
        check({tag, ".result_held"}, result, er);
        check({tag, ".flags_held"}, W'({div_by_zero, illegal_op}), W'({edz, eil}));
    endtask

    task automatic reset_mid_op();
        int n_done = 0;
        op = 2'd0; a = 64'd7; b = 64'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid.busy", W'(busy), '0);
        check("rst_mid.result", result, '0);
        check("rst_mid.done", W'(done), '0);
        check("rst_mid.alu_req", W'(alu_req), '0);
        repeat (80) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        check("rst_mid.no_done", W'(n_done), '0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; alu_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", W'(busy), '0);
        check("reset.done", W'(done), '0);
        check("reset.result", result, '0);
        check("reset.flags", W'({div_by_zero, illegal_op}), '0);
        check("reset.alu_req", W'(alu_req), '0);
        check("reset.alu_f", W'(alu_f), W'(4'b0010));
        check("reset.alu_ops", alu_opA | alu_opB, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 64'd7, 64'd6, 0, 1'b0, "mul_7x6");
        run_op(2'd1, 64'd100, 64'd7, 0, 1'b0, "udiv_100_7");
        run_op(2'd2, 64'd100, 64'd7, 0, 1'b0, "urem_100_7");
        run_op(2'd1, 64'd5, 64'd0, 0, 1'b0, "udiv_by0");
        run_op(2'd2, 64'd5, 64'd0, 0, 1'b0, "urem_by0");
        run_op(2'd1, '1, 64'h8000_0000_0000_0001, 0, 1'b0, "udiv_msb");
        run_op(2'd2, '1, 64'h8000_0000_0000_0001, 0, 1'b0, "urem_msb");
        run_op(2'd0, 64'd3, 64'd5, 1, 1'b1, "mul_stall");
        reset_mid_op();
        run_op(2'd3, 64'd9, 64'd4, 0, 1'b0, "illegal");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       ry = {1'b1, 31'($urandom), $urandom};
                default: ry = {$urandom, $urandom};
            endcase
            run_op(ro, rx, ry, int'($urandom_range(0, 2)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
